regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port (regWrite/writeReg/writeData) between two writeback sources: ALU results and memory loads.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 85 ++++++++
 rtl/regfile_wb_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Holds the register/data widths, the FSM state type and the FIFO entry layout.
package regfile_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_INIT = 2'd2
    } state_t;

    typedef struct packed {
        logic [REG_W-1:0]  wreg;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO for one writeback source.
// Also reports whether any live entry targets either decode read address.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             i_push,
    input  wb_entry_t        i_entry,
    input  logic             i_pop,
    output wb_entry_t        o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count,
    input  logic [REG_W-1:0] i_rs_addr,
    input  logic [REG_W-1:0] i_rt_addr,
    output logic             o_rs_match,
    output logic             o_rt_match
);

    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    wb_entry_t       r_mem [DEPTH];

    logic            w_push_ok;
    logic            w_pop_ok;
    logic [DEPTH-1:0] w_live;
    logic [DEPTH-1:0] w_rs_hit;
    logic [DEPTH-1:0] w_rt_hit;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == {(AW+1){1'b0}});
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + {{AW{1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{AW{1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until covered by the occupancy count.
    always_ff @(posedge clock_in) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        w_live   = {DEPTH{1'b0}};
        w_rs_hit = {DEPTH{1'b0}};
        w_rt_hit = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            w_live[i]   = ({1'b0, AW'(i) - r_rd_ptr} < r_count);
            w_rs_hit[i] = (r_mem[i].wreg == i_rs_addr);
            w_rt_hit[i] = (r_mem[i].wreg == i_rt_addr);
        end
    end

    assign o_rs_match = |(w_live & w_rs_hit);
    assign o_rt_match = |(w_live & w_rt_hit);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between ALU and load writebacks,
// with a round-robin drain, an upper-bank clear sweep and a decode hazard flag.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int                DEPTH      = 2,
    parameter int                INIT_FIRST = 16,
    parameter int                INIT_LAST  = 31,
    parameter logic [DATA_W-1:0] INIT_VALUE = 32'h00000000,
    localparam int               AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_W-1:0]  alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [REG_W-1:0]  mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              init_start,
    output logic              init_busy,
    input  logic [REG_W-1:0]  rs_addr,
    input  logic [REG_W-1:0]  rt_addr,
    output logic              hazard,
    output logic              regWrite,
    output logic [REG_W-1:0]  writeReg,
    output logic [DATA_W-1:0] writeData,
    output logic              grant_id
);

    state_t            r_state;
    logic              r_rr_last;
    logic [REG_W-1:0]  r_init_cnt;
    logic              r_regWrite;
    logic [REG_W-1:0]  r_writeReg;
    logic [DATA_W-1:0] r_writeData;
    logic              r_grant_id;
    logic              r_init_busy;

    state_t            w_state_nxt;
    logic              w_rr_nxt;
    logic [REG_W-1:0]  w_cnt_nxt;
    logic              w_we_nxt;
    logic [REG_W-1:0]  w_reg_nxt;
    logic [DATA_W-1:0] w_data_nxt;
    logic              w_gid_nxt;

    wb_entry_t         w_alu_head;
    wb_entry_t         w_mem_head;
    wb_entry_t         w_head;
    logic              w_alu_full,  w_mem_full;
    logic              w_alu_empty, w_mem_empty;
    logic [AW:0]       w_alu_count, w_mem_count;
    logic              w_alu_rs_m,  w_alu_rt_m;
    logic              w_mem_rs_m,  w_mem_rt_m;
    logic              w_alu_push,  w_mem_push;
    logic              w_pop_alu,   w_pop_mem;
    logic              w_arb_go;
    logic              w_grant;
    logic              w_any_left;
    logic              w_rs_haz,    w_rt_haz;

    assign alu_ready  = !w_alu_full;
    assign mem_ready  = !w_mem_full;
    assign w_alu_push = alu_valid && alu_ready;
    assign w_mem_push = mem_valid && mem_ready;

    wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
        .clock_in   (clock_in),
        .reset      (reset),
        .i_push     (w_alu_push),
        .i_entry    ({alu_reg, alu_data}),
        .i_pop      (w_pop_alu),
        .o_head     (w_alu_head),
        .o_full     (w_alu_full),
        .o_empty    (w_alu_empty),
        .o_count    (w_alu_count),
        .i_rs_addr  (rs_addr),
        .i_rt_addr  (rt_addr),
        .o_rs_match (w_alu_rs_m),
        .o_rt_match (w_alu_rt_m)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
        .clock_in   (clock_in),
        .reset      (reset),
        .i_push     (w_mem_push),
        .i_entry    ({mem_reg, mem_data}),
        .i_pop      (w_pop_mem),
        .o_head     (w_mem_head),
        .o_full     (w_mem_full),
        .o_empty    (w_mem_empty),
        .o_count    (w_mem_count),
        .i_rs_addr  (rs_addr),
        .i_rt_addr  (rt_addr),
        .o_rs_match (w_mem_rs_m),
        .o_rt_match (w_mem_rt_m)
    );

    // A pop happens only outside the sweep and never on the edge that starts one.
    assign w_arb_go = (r_state != ST_INIT) && !init_start && (!w_alu_empty || !w_mem_empty);

    // Round-robin pick: 0 = ALU, 1 = MEM; the pointer only moves on contention.
    always_comb begin
        w_grant  = 1'b0;
        w_rr_nxt = r_rr_last;
        if (!w_alu_empty && !w_mem_empty) begin
            w_grant  = ~r_rr_last;
            w_rr_nxt = w_arb_go ? ~r_rr_last : r_rr_last;
        end else begin
            w_grant  = w_alu_empty;
        end
    end

    assign w_pop_alu  = w_arb_go && !w_grant;
    assign w_pop_mem  = w_arb_go && w_grant;
    assign w_head     = w_grant ? w_mem_head : w_alu_head;
    assign w_any_left = w_alu_push || w_mem_push
                     || (w_alu_count > {{AW{1'b0}}, w_pop_alu})
                     || (w_mem_count > {{AW{1'b0}}, w_pop_mem});

    // Next state and next write-port contents.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_init_cnt;
        w_we_nxt    = 1'b0;
        w_reg_nxt   = r_writeReg;
        w_data_nxt  = r_writeData;
        w_gid_nxt   = r_grant_id;
        case (r_state)
            ST_IDLE, ST_ARB: begin
                if (init_start) begin
                    w_state_nxt = ST_INIT;
                    w_cnt_nxt   = REG_W'(INIT_FIRST);
                    w_gid_nxt   = 1'b0;
                end else if (w_arb_go) begin
                    w_state_nxt = w_any_left ? ST_ARB : ST_IDLE;
                    w_we_nxt    = (w_head.wreg != REG_ZERO);
                    w_reg_nxt   = w_head.wreg;
                    w_data_nxt  = w_head.data;
                    w_gid_nxt   = w_grant;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_INIT: begin
                w_we_nxt   = (r_init_cnt != REG_ZERO);
                w_reg_nxt  = r_init_cnt;
                w_data_nxt = INIT_VALUE;
                w_gid_nxt  = 1'b0;
                if (r_init_cnt == REG_W'(INIT_LAST)) begin
                    w_state_nxt = w_any_left ? ST_ARB : ST_IDLE;
                end else begin
                    w_cnt_nxt   = r_init_cnt + 5'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, arbitration pointer, sweep counter and write-port registers.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rr_last   <= 1'b1;
            r_init_cnt  <= REG_ZERO;
            r_regWrite  <= 1'b0;
            r_writeReg  <= REG_ZERO;
            r_writeData <= 32'h00000000;
            r_grant_id  <= 1'b0;
            r_init_busy <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_last   <= w_rr_nxt;
            r_init_cnt  <= w_cnt_nxt;
            r_regWrite  <= w_we_nxt;
            r_writeReg  <= w_reg_nxt;
            r_writeData <= w_data_nxt;
            r_grant_id  <= w_gid_nxt;
            r_init_busy <= (w_state_nxt == ST_INIT);
        end
    end

    // Registers from the sweep counter up to INIT_LAST are still stale while busy.
    assign w_rs_haz = (rs_addr != REG_ZERO) && (w_alu_rs_m || w_mem_rs_m
                   || (r_regWrite && (r_writeReg == rs_addr))
                   || (r_init_busy && (rs_addr >= r_init_cnt) && (rs_addr <= REG_W'(INIT_LAST))));
    assign w_rt_haz = (rt_addr != REG_ZERO) && (w_alu_rt_m || w_mem_rt_m
                   || (r_regWrite && (r_writeReg == rt_addr))
                   || (r_init_busy && (rt_addr >= r_init_cnt) && (rt_addr <= REG_W'(INIT_LAST))));

    assign hazard    = w_rs_haz || w_rt_haz;
    assign regWrite  = r_regWrite;
    assign writeReg  = r_writeReg;
    assign writeData = r_writeData;
    assign grant_id  = r_grant_id;
    assign init_busy = r_init_busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed + randomized bench for regfile_wb_arbiter, checked against a
// queue-based transaction model of the writeback and clear-sweep rules.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    logic        clock_in = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid, init_start;
    logic [4:0]  alu_reg, mem_reg, rs_addr, rt_addr;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready, init_busy, hazard, regWrite, grant_id;
    logic [4:0]  writeReg;
    logic [31:0] writeData;

    regfile_wb_arbiter dut (
        .clock_in (clock_in), .reset (reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
        .init_start(init_start), .init_busy(init_busy),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .hazard(hazard),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData), .grant_id(grant_id)
    );

    always #5 clock_in = ~clock_in;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    ent_t        aq[$];
    ent_t        mq[$];
    int          sweep;        // next register to clear, -1 when no sweep
    bit          prefer_mem;   // source to favour on the next contended pop
    bit          acc_m;        // last edge accepted a MEM entry
    logic        e_we, e_gid, e_busy;
    logic [4:0]  e_reg;
    logic [31:0] e_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        aq.delete();
        mq.delete();
        sweep      = -1;
        prefer_mem = 1'b0;
        acc_m      = 1'b0;
        e_we = 1'b0; e_gid = 1'b0; e_busy = 1'b0; e_reg = 5'd0; e_data = 32'h0;
    endtask

    function automatic bit pending(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        foreach (aq[i]) if (aq[i].r == a) return 1'b1;
        foreach (mq[i]) if (mq[i].r == a) return 1'b1;
        if (e_we && e_reg == a) return 1'b1;
        if (sweep >= 0 && int'(a) >= sweep && int'(a) <= 31) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge();
        bit   pa, pm, g;
        ent_t e;
        pa    = alu_valid && (aq.size() < DEPTH);
        pm    = mem_valid && (mq.size() < DEPTH);
        acc_m = pm;
        e_we  = 1'b0;
        if (sweep >= 0) begin
            e_we = 1'b1; e_reg = 5'(sweep); e_data = 32'h0; e_gid = 1'b0;
            sweep = (sweep == 31) ? -1 : sweep + 1;
        end else if (init_start) begin
            sweep = 16;
            e_gid = 1'b0;
        end else if (aq.size() + mq.size() > 0) begin
            if (aq.size() > 0 && mq.size() > 0) begin
                g = prefer_mem;
                prefer_mem = !prefer_mem;
            end else begin
                g = (aq.size() == 0);
            end
            e = g ? mq.pop_front() : aq.pop_front();
            e_we = (e.r != 5'd0); e_reg = e.r; e_data = e.d; e_gid = g;
        end
        if (pa) begin e = {alu_reg, alu_data}; aq.push_back(e); end
        if (pm) begin e = {mem_reg, mem_data}; mq.push_back(e); end
        e_busy = (sweep >= 0);
    endtask

    task automatic tick();
        @(negedge clock_in);
        chk("alu_ready", {31'd0, alu_ready}, {31'd0, aq.size() < DEPTH});
        chk("mem_ready", {31'd0, mem_ready}, {31'd0, mq.size() < DEPTH});
        chk("hazard", {31'd0, hazard}, {31'd0, pending(rs_addr) || pending(rt_addr)});
        model_edge();
        @(posedge clock_in);
        #1;
        chk("regWrite",  {31'd0, regWrite},  {31'd0, e_we});
        chk("writeReg",  {27'd0, writeReg},  {27'd0, e_reg});
        chk("writeData", writeData,          e_data);
        chk("grant_id",  {31'd0, grant_id},  {31'd0, e_gid});
        chk("init_busy", {31'd0, init_busy}, {31'd0, e_busy});
    endtask

    initial begin
        logic [31:0] seen[4];
        logic [31:0] t3_data[3];
        int          sent, nwr;

        reset = 1'b1;
        alu_valid = 1'b0; mem_valid = 1'b0; init_start = 1'b0;
        alu_reg = 5'd0; mem_reg = 5'd0; alu_data = 32'h0; mem_data = 32'h0;
        rs_addr = 5'd0; rt_addr = 5'd0;
        model_reset();
        repeat (2) @(posedge clock_in);
        #1;
        chk("rst_regWrite",  {31'd0, regWrite},  32'd0);
        chk("rst_writeReg",  {27'd0, writeReg},  32'd0);
        chk("rst_writeData", writeData,          32'd0);
        chk("rst_grant",     {31'd0, grant_id},  32'd0);
        chk("rst_busy",      {31'd0, init_busy}, 32'd0);
        reset = 1'b0;
        tick();

        // Single ALU push
        alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hA5; rs_addr = 5'd5;
        tick();
        alu_valid = 1'b0;
        tick();
        chk("t1_regWrite", {31'd0, regWrite}, 32'd1);
        chk("t1_writeReg", {27'd0, writeReg}, 32'd5);
        chk("t1_data",     writeData,         32'hA5);
        tick();

        // Both sources push two entries on the same edges
        alu_valid = 1'b1; mem_valid = 1'b1;
        alu_reg = 5'd1; alu_data = 32'hA0; mem_reg = 5'd2; mem_data = 32'hB0;
        tick();
        alu_reg = 5'd3; alu_data = 32'hA1; mem_reg = 5'd4; mem_data = 32'hB1;
        tick();
        seen[0] = writeData;
        alu_valid = 1'b0; mem_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();
            seen[i] = writeData;
        end
        chk("t2_w0", seen[0], 32'hA0);
        chk("t2_w1", seen[1], 32'hB0);
        chk("t2_w2", seen[2], 32'hA1);
        chk("t2_w3", seen[3], 32'hB1);
        tick();

        // Clear sweep from idle with decode reading r20
        rs_addr = 5'd20; rt_addr = 5'd0;
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        nwr = 0;
        for (int i = 0; i < 17; i++) begin
            tick();
            if (regWrite === 1'b1) nwr++;
        end
        chk("t4_writes", nwr, 32'd16);
        chk("t4_last_reg", {27'd0, writeReg}, 32'd31);

        // Loads held valid while the sweep blocks all pops
        t3_data[0] = 32'hC0; t3_data[1] = 32'hC1; t3_data[2] = 32'hC2;
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        sent = 0;
        for (int i = 0; i < 24; i++) begin
            mem_valid = (sent < 3);
            mem_reg   = 5'(8 + sent);
            mem_data  = t3_data[sent % 3];
            tick();
            if (acc_m) sent++;
            if (i == 4) chk("t3_mem_ready_full", {31'd0, mem_ready}, 32'd0);
        end
        mem_valid = 1'b0;
        chk("t3_sent", sent, 32'd3);
        repeat (4) tick();

        // Writeback to r0 is consumed without a write
        rs_addr = 5'd0; rt_addr = 5'd0;
        alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'hFF;
        tick();
        alu_valid = 1'b0;
        tick();
        chk("t5_regWrite", {31'd0, regWrite}, 32'd0);
        chk("t5_data",     writeData,         32'hFF);
        tick();

        // Reset in the middle of a sweep with entries queued
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'h77;
        mem_valid = 1'b1; mem_reg = 5'd9; mem_data = 32'h99;
        rs_addr = 5'd7;
        repeat (3) tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("t6_regWrite", {31'd0, regWrite},  32'd0);
        chk("t6_busy",     {31'd0, init_busy}, 32'd0);
        chk("t6_alu_rdy",  {31'd0, alu_ready}, 32'd1);
        chk("t6_mem_rdy",  {31'd0, mem_ready}, 32'd1);
        chk("t6_hazard",   {31'd0, hazard},    32'd0);
        @(posedge clock_in);
        #1;
        reset = 1'b0;
        model_reset();
        tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            alu_valid  = ($urandom_range(0, 2) != 0);
            mem_valid  = ($urandom_range(0, 2) != 0);
            alu_reg    = 5'($urandom_range(0, 31));
            mem_reg    = 5'($urandom_range(0, 31));
            alu_data   = $urandom;
            mem_data   = $urandom;
            init_start = ($urandom_range(0, 39) == 0);
            rs_addr    = 5'($urandom_range(0, 31));
            rt_addr    = 5'($urandom_range(0, 31));
            tick();
        end
        alu_valid = 1'b0; mem_valid = 1'b0; init_start = 1'b0;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
